// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, frame constants and sizing helpers for the UART transmit path
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} arb_state_t;
  typedef enum logic [1:0] {PH_START, PH_DATA, PH_STOP} ser_phase_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int FRAME_BITS = 10;
  function automatic int clks_per_bit(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first frame shifter with baud and bit counters
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 260
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = cnt_width(CLKS_PER_BIT);
  ser_phase_t phase, nxt_phase;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic baud_end;
  assign baud_end = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign done = busy && phase == PH_STOP && baud_end;
  assign tx = !busy ? UART_IDLE_LEVEL :
              phase == PH_START ? 1'b0 :
              phase == PH_DATA ? shreg[bit_idx] : 1'b1;
  always_comb begin
    nxt_phase = phase;
    if (!busy)
      nxt_phase = PH_START;
    else if (baud_end)
      nxt_phase = (phase == PH_START) ? PH_DATA :
                  (phase == PH_DATA && bit_idx == 3'd7) ? PH_STOP : phase;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      phase    <= PH_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      phase    <= nxt_phase;
      busy     <= busy ? !done : start;
      baud_cnt <= (!busy || baud_end) ? '0 : baud_cnt + 1'b1;
      bit_idx  <= !busy ? '0 : (baud_end && phase == PH_DATA) ? bit_idx + 1'b1 : bit_idx;
      shreg    <= (!busy && start) ? data : shreg;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locked sharing of one UART transmit line
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_FREQ_HZ  = 30_000_000,
  parameter int BAUD         = 115200,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int TW  = cnt_width(LOCK_TIMEOUT);
  arb_state_t state, nxt_state;
  logic [IW-1:0] gid, nxt_gid, rr_ptr, nxt_rr;
  logic [TW-1:0] to_cnt, nxt_to;
  logic last_q, nxt_last, start, done;
  logic [IW:0] pick;
  // Scan farthest-to-nearest so the nearest index after rr_ptr wins.
  function automatic logic [IW:0] rr_pick(logic [NUM_REQ-1:0] v, logic [IW-1:0] p);
    logic [IW-1:0] j;
    rr_pick = '0;
    j = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      j = IW'((int'(p) + k) % NUM_REQ);
      if (v[j]) rr_pick = {1'b1, j};
    end
  endfunction
  assign pick = rr_pick(req_valid, rr_ptr);
  assign grant_valid = state != ST_IDLE;
  assign grant_id = grant_valid ? gid : '0;
  always_comb begin
    nxt_state = state;
    nxt_gid   = gid;
    nxt_rr    = rr_ptr;
    nxt_to    = to_cnt;
    nxt_last  = last_q;
    req_ready = '0;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_to = '0;
        if (pick[IW]) begin
          nxt_state = ST_LOAD;
          nxt_gid   = pick[IW-1:0];
        end
      end
      ST_LOAD: begin
        req_ready[gid] = req_valid[gid];
        start = req_valid[gid];
        if (req_valid[gid]) begin
          nxt_last  = req_last[gid];
          nxt_to    = '0;
          nxt_state = ST_SEND;
        end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
          nxt_state = ST_IDLE;
          nxt_rr    = gid;
        end else
          nxt_to = to_cnt + 1'b1;
      end
      ST_SEND: if (done) begin
        nxt_state = last_q ? ST_IDLE : ST_LOAD;
        nxt_rr    = last_q ? gid : rr_ptr;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      gid    <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      to_cnt <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      gid    <= nxt_gid;
      rr_ptr <= nxt_rr;
      to_cnt <= nxt_to;
      last_q <= nxt_last;
    end
  end
  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_ser (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (req_data[8*gid +: 8]),
    .tx   (uart_tx),
    .busy (busy),
    .done (done)
  );
endmodule
